// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop computes a - b LSB first,
// with a start/busy/done handshake and registered result, borrow and signed-overflow outputs.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             bor_out_q, bor_out_d, ovf_q, ovf_d;
  logic             x, y, d_bit, bout, last_bit;

  // Full-subtractor cell on the operand LSBs.
  always_comb begin
    x        = a_q[0];
    y        = b_q[0];
    d_bit    = x ^ y ^ borrow_q;
    bout     = (~x & y) | (~(x ^ y) & borrow_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      diff_q    <= '0;
      cnt_q     <= '0;
      borrow_q  <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      bor_out_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      diff_q    <= diff_d;
      cnt_q     <= cnt_d;
      borrow_q  <= borrow_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      bor_out_q <= bor_out_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    bor_out_d = bor_out_q;
    ovf_d     = ovf_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      a_d      = a;
      b_d      = b;
      res_d    = '0;
      cnt_d    = '0;
      borrow_d = 1'b0;
      a_msb_d  = a[WIDTH-1];
      b_msb_d  = b[WIDTH-1];
    end else if (state_q == SHIFT) begin
      a_d      = a_q >> 1;
      b_d      = b_q >> 1;
      res_d    = {d_bit, res_q[WIDTH-1:1]};
      borrow_d = bout;
      cnt_d    = cnt_q + CW'(1);
      // Result outputs only change on the final bit, so shift values never leak out.
      if (last_bit) begin
        diff_d    = {d_bit, res_q[WIDTH-1:1]};
        bor_out_d = bout;
        ovf_d     = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
      end
    end
  end

  always_comb begin
    busy       = (state_q == SHIFT);
    done       = (state_q == DONE);
    diff       = diff_q;
    borrow_out = bor_out_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: a cycle-timeline arithmetic model checks the 8-bit instance every cycle,
// directed vectors pin literal results, and a 2-bit instance is swept exhaustively.
module tb_serial_subtractor;

  localparam int W8 = 8;
  localparam int W2 = 2;

  typedef struct packed {
    logic [31:0] d;
    logic        bor;
    logic        ovf;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, start2 = 1'b0;
  logic [W8-1:0] a = '0, b = '0, diff;
  logic [W2-1:0] a2 = '0, b2 = '0, diff2;
  logic          busy, done, borrow_out, overflow;
  logic          busy2, done2, borrow_out2, overflow2;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  serial_subtractor #(.WIDTH(W8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );

  serial_subtractor #(.WIDTH(W2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow_out(borrow_out2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: plain modular and signed arithmetic on w-bit operands.
  function automatic res_t ref_sub(input int w, input int ia, input int ib);
    res_t r;
    int   sa, sb, sd;
    sa    = (ia >= (1 << (w - 1))) ? ia - (1 << w) : ia;
    sb    = (ib >= (1 << (w - 1))) ? ib - (1 << w) : ib;
    sd    = sa - sb;
    r.d   = 32'((ia - ib) & ((1 << w) - 1));
    r.bor = (ia < ib);
    r.ovf = (sd > (1 << (w - 1)) - 1) || (sd < -(1 << (w - 1)));
    return r;
  endfunction

  // Timeline model: m_t counts cycles since acceptance (0 = idle, W8+1 = done cycle).
  int            m_t = 0;
  res_t          m_pend;
  logic [W8-1:0] m_diff = '0;
  logic          m_bor = 1'b0, m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t    <= 0;
      m_diff <= '0;
      m_bor  <= 1'b0;
      m_ovf  <= 1'b0;
    end else if ((m_t == 0 || m_t == W8 + 1) && start) begin
      m_t    <= 1;
      m_pend <= ref_sub(W8, int'(a), int'(b));
    end else if (m_t == W8 + 1) begin
      m_t <= 0;
    end else if (m_t > 0) begin
      m_t <= m_t + 1;
      if (m_t == W8) begin
        m_diff <= m_pend.d[W8-1:0];
        m_bor  <= m_pend.bor;
        m_ovf  <= m_pend.ovf;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, (m_t >= 1 && m_t <= W8));
    check("done", done, (m_t == W8 + 1));
    check("diff", diff, m_diff);
    check("borrow_out", borrow_out, m_bor);
    check("overflow", overflow, m_ovf);
  end

  task automatic wait_done(input string tag, output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 3 * W8; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({tag, " done seen"}, seen, 1);
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ed,
                        input logic eb, input logic eo, input string tag);
    int lat;
    @(posedge clk); #1;
    start = 1'b1; a = ia; b = ib;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    wait_done(tag, lat);
    check({tag, " latency"}, lat, W8 + 1);
    check({tag, " diff"}, diff, ed);
    check({tag, " borrow"}, borrow_out, eb);
    check({tag, " overflow"}, overflow, eo);
  endtask

  task automatic run2(input int ia, input int ib);
    res_t r;
    bit   seen = 0;
    r = ref_sub(W2, ia, ib);
    @(posedge clk); #1;
    start2 = 1'b1; a2 = 2'(ia); b2 = 2'(ib);
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 4 * W2; i++) begin
      @(negedge clk);
      if (done2) begin
        seen = 1;
        break;
      end
    end
    check($sformatf("w2 %0d-%0d done", ia, ib), seen, 1);
    check($sformatf("w2 %0d-%0d diff", ia, ib), diff2, r.d[W2-1:0]);
    check($sformatf("w2 %0d-%0d borrow", ia, ib), borrow_out2, r.bor);
    check($sformatf("w2 %0d-%0d ovf", ia, ib), overflow2, r.ovf);
  endtask

  initial begin
    bit seen;
    int lat;

    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset diff", diff, 0);
    check("reset borrow", borrow_out, 0);
    check("reset overflow", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "5-3");
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "3-5");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "80-01");
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "7F-FF");

    // Back-to-back: start held through the whole first operation.
    @(posedge clk); #1;
    start = 1'b1; a = 8'h00; b = 8'h00;
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55;
    wait_done("b2b first", lat);
    check("b2b first latency", lat, W8 + 1);
    check("b2b first diff", diff, 8'h00);
    check("b2b first borrow", borrow_out, 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b second", lat);
    check("b2b second latency", lat, W8 + 1);
    check("b2b second diff", diff, 8'h55);
    check("b2b second borrow", borrow_out, 0);
    check("b2b second overflow", overflow, 1);

    // Abort with reset after four bits have been processed.
    @(posedge clk); #1;
    start = 1'b1; a = 8'h10; b = 8'h20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort diff", diff, 0);
    check("abort borrow", borrow_out, 0);
    check("abort overflow", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (2 * W8) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("abort stays idle", seen, 0);
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, "10-20");

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        run2(i, j);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor. It computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the team's full-adder datapath. It sits beside the adder blocks in the arithmetic lab design and exposes a start/busy/done handshake so a controller or a self-checking bench can sequence operands through it.

## Interface
- `WIDTH`, default 8: operand and result width in bits, minimum 2.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: asynchronous, active-high reset.
- `start`  input  1: request an operation. Sampled on a rising edge of `clk`.
- `a`  input  WIDTH: minuend, captured on the accepted `start`.
- `b`  input  WIDTH: subtrahend, captured on the accepted `start`.
- `busy`  output  1: high while bits are being processed.
- `done`  output  1: one-cycle pulse when the result is valid.
- `diff`  output  WIDTH: `a - b` modulo 2^WIDTH.
- `borrow_out`  output  1: final borrow. It is 1 iff `a < b` when both are treated as unsigned.
- `overflow`  output  1: signed two's-complement overflow of `a - b`.

## Operation
- Clock and reset:
  - One clock domain is used.
  - `rst` is asynchronous and active-high.
  - Reset forces state IDLE and clears all of the following: `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `overflow`=0, the internal shift registers, the borrow flip-flop and the bit counter.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - With `start`=1 at the edge, the block loads `a` and `b` into the shift registers, clears the borrow flip-flop, sets the counter to 0 and goes to SHIFT.
  - Otherwise it stays in IDLE.
- SHIFT, once per cycle with x = LSB of the A register, y = LSB of the B register, bin = borrow flip-flop:
  - Difference bit: d = x ^ y ^ bin.
  - Next borrow: bout = (~x & y) | (~(x ^ y) & bin).
  - The result register shifts right with d inserted at the MSB.
  - The A and B registers shift right.
  - The borrow flip-flop is loaded with bout.
  - The counter increments.
  - After the WIDTH-th bit, the block goes to DONE.
- DONE:
  - Outputs update as follows:
    - `diff` is the result register.
    - `borrow_out` is the final borrow.
    - `overflow` = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), computed from the captured operand MSBs.
  - `done`=1 for exactly this one cycle.
  - With `start`=1, new operands are loaded and the block goes to SHIFT (back-to-back operation). Otherwise it goes to IDLE.
- `start` while in SHIFT is ignored. The operation in flight is not disturbed, and no queuing takes place.
- `a` and `b` may change freely after the accepting edge. Only the captured copies are used.
- `diff`, `borrow_out` and `overflow` hold their last values until the next DONE. Intermediate shift values never appear on them.
- Reset mid-operation aborts the operation, produces no `done` pulse, and returns all outputs to their reset values.

## Timing
- Let edge E0 be the edge at which `start`=1 is accepted.
- `busy`:
  - Rises after E0.
  - Stays high for exactly WIDTH cycles, through edges E1..E_WIDTH.
  - Falls after E_WIDTH.
- `done`:
  - High for exactly one cycle, from edge E_WIDTH to edge E_WIDTH+1.
  - Result outputs are valid from that same cycle onward.
- Latency from accept to `done` is WIDTH cycles. Throughput is one operation per WIDTH+1 cycles back-to-back.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset and basic subtraction:
  - Stimulus: assert `rst`, check that all outputs are 0; then, with WIDTH=8, start with `a`=0x05 and `b`=0x03.
  - Response: after 8 busy cycles, `done` pulses with `diff`=0x02, `borrow_out`=0 and `overflow`=0.
- Unsigned borrow: `a`=0x03, `b`=0x05 -> `diff`=0xFE, `borrow_out`=1, `overflow`=0.
- Signed overflow cases:
  - `a`=0x80, `b`=0x01 -> `diff`=0x7F, `borrow_out`=0, `overflow`=1.
  - `a`=0x7F, `b`=0xFF -> `diff`=0x80, `borrow_out`=1, `overflow`=1.
- Back-to-back with ignored start:
  - Stimulus: hold `start` high through the first operation (`a`=0x00, `b`=0x00), while presenting `a`=0xAA and `b`=0x55 from the second cycle on.
  - Response:
    - The first `done` shows `diff`=0x00 and `borrow_out`=0.
    - Starts during SHIFT are ignored.
    - The start sampled in the DONE cycle is accepted, and 8 cycles later `done` shows `diff`=0x55, `borrow_out`=0 and `overflow`=1.
- Reset mid-operation and exhaustive sweep:
  - Stimulus: assert `rst` at bit 4 of `a`=0x10, `b`=0x20.
  - Response: no `done` pulse, all outputs 0 and state IDLE; a following start with `a`=0x10, `b`=0x20 yields `diff`=0xF0 and `borrow_out`=1.
  - Sweep: finish with an exhaustive WIDTH=2 sweep of all 16 operand pairs, checked against a reference model.
